// File: rtl/psx_input_events_if.sv
// Signal bundle between the PSX poller side (master) and the input-event decoder (slave).
interface psx_input_events_if;
    logic [15:0] button_state;
    logic [31:0] stick_state;
    logic        jump_pulse;
    logic        duck;
    logic        start_pulse;
    logic [15:0] btn_stable;

    modport master (
        output button_state,
        output stick_state,
        input  jump_pulse,
        input  duck,
        input  start_pulse,
        input  btn_stable
    );

    modport slave (
        input  button_state,
        input  stick_state,
        output jump_pulse,
        output duck,
        output start_pulse,
        output btn_stable
    );
endinterface

// File: rtl/psx_input_events.sv
// Debounces PSX buttons and left-stick Y zones, then decodes them into
// jump/start pulses and a duck level for the runner game. Runs on negedge like the poller.
module psx_input_events #(
    parameter int          STABLE_CYCLES = 2000,
    parameter logic [7:0]  UP_ENTER      = 8'h40,
    parameter logic [7:0]  UP_EXIT       = 8'h60,
    parameter logic [7:0]  DOWN_ENTER    = 8'hC0,
    parameter logic [7:0]  DOWN_EXIT     = 8'hA0
) (
    input  logic              clk,
    input  logic              rst,
    psx_input_events_if.slave bus
);
    localparam int              CW   = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(STABLE_CYCLES - 1);

    logic [7:0]    ly;
    logic          up_zone;
    logic          down_zone;
    logic [17:0]   raw;
    logic [17:0]   cand;
    logic [17:0]   stable;
    logic [CW-1:0] cnt;
    logic          j_new;
    logic          j_old;
    logic          d_new;
    logic          s_new;
    logic          s_old;
    logic          unused_stick;

    assign ly           = bus.stick_state[7:0];
    assign unused_stick = ^bus.stick_state[31:8];

    // Bit 17 = down zone, bit 16 = up zone, [15:0] = buttons made active-high.
    assign raw = {down_zone, up_zone, ~bus.button_state};

    // Jump (Cross, Up, stick up) overrides duck (Down, stick down).
    assign j_new = cand[1] | cand[11] | cand[16];
    assign d_new = (cand[9] | cand[17]) & ~j_new;
    assign s_new = cand[12];
    assign j_old = stable[1] | stable[11] | stable[16];
    assign s_old = stable[12];

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            up_zone         <= 1'b0;
            down_zone       <= 1'b0;
            cand            <= '0;
            stable          <= '0;
            cnt             <= '0;
            bus.jump_pulse  <= 1'b0;
            bus.start_pulse <= 1'b0;
            bus.duck        <= 1'b0;
        end else begin
            if (ly <= UP_ENTER) begin
                up_zone <= 1'b1;
            end else if (ly >= UP_EXIT) begin
                up_zone <= 1'b0;
            end

            if (ly >= DOWN_ENTER) begin
                down_zone <= 1'b1;
            end else if (ly <= DOWN_EXIT) begin
                down_zone <= 1'b0;
            end

            bus.jump_pulse  <= 1'b0;
            bus.start_pulse <= 1'b0;

            // One window shared by all bits: any change restarts it.
            if (raw != cand) begin
                cand <= raw;
                cnt  <= '0;
            end else if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                stable          <= cand;
                bus.jump_pulse  <= j_new & ~j_old;
                bus.start_pulse <= s_new & ~s_old;
                bus.duck        <= d_new;
            end
        end
    end

    assign bus.btn_stable = stable[15:0];
endmodule

// File: tb/tb_psx_input_events.sv
// Scoreboard bench for psx_input_events with STABLE_CYCLES=4: stimulus pushes expected
// output events (cycle, jump, start, duck, btn_stable); a monitor pops and compares them.
module tb_psx_input_events;
    logic clk;
    logic rst;
    logic [15:0] cyc;
    int tests;
    int fails;

    // {cycle[34:19], jump[18], start[17], duck[16], btn[15:0]}
    logic [34:0] exp_q[$];
    logic        prev_duck;
    logic [15:0] prev_btn;

    psx_input_events_if bus();

    psx_input_events #(.STABLE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 16'd0;
    always @(negedge clk) cyc <= cyc + 16'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive(input logic [15:0] b, input logic [7:0] ly);
        bus.button_state = b;
        bus.stick_state  = {24'h808080, ly};
    endtask

    task automatic expect_ev(input int off, input logic jp, input logic sp,
                             input logic dk, input logic [15:0] btn);
        exp_q.push_back({cyc + 16'(off), jp, sp, dk, btn});
    endtask

    // Monitor: every visible output change or pulse must match the queue head.
    always @(posedge clk) begin
        logic [34:0] head;
        logic [34:0] obs;
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0][34:19] < cyc) begin
                head = exp_q.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_event: actual none required %h", head);
            end
            if (bus.jump_pulse || bus.start_pulse || bus.duck != prev_duck ||
                bus.btn_stable != prev_btn) begin
                obs = {cyc, bus.jump_pulse, bus.start_pulse, bus.duck, bus.btn_stable};
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: actual %h required none", obs);
                end else begin
                    head = exp_q.pop_front();
                    if (obs !== head) begin
                        fails++;
                        $display("FAIL event: actual %h required %h", obs, head);
                    end
                end
            end
        end
        prev_duck = bus.duck;
        prev_btn  = bus.btn_stable;
    end

    initial begin
        tests     = 0;
        fails     = 0;
        prev_duck = 1'b0;
        prev_btn  = 16'h0000;
        rst       = 1'b1;
        drive(16'hFFFF, 8'h80);

        // Reset with idle inputs
        tick(3);
        check("rst_jump",  {31'd0, bus.jump_pulse},  32'd0);
        check("rst_start", {31'd0, bus.start_pulse}, 32'd0);
        check("rst_duck",  {31'd0, bus.duck},        32'd0);
        check("rst_btn",   {16'd0, bus.btn_stable},  32'd0);
        rst = 1'b0;
        tick(50);
        check("idle_jump", {31'd0, bus.jump_pulse}, 32'd0);
        check("idle_duck", {31'd0, bus.duck},       32'd0);
        check("idle_btn",  {16'd0, bus.btn_stable}, 32'd0);

        // Cross press, glitch rejection while held, release, re-press
        drive(16'hFFFD, 8'h80); expect_ev(5, 1, 0, 0, 16'h0002); tick(10);
        drive(16'hFFFF, 8'h80); tick(3);
        drive(16'hFFFD, 8'h80); tick(10);
        drive(16'hFFFF, 8'h80); expect_ev(5, 0, 0, 0, 16'h0000); tick(10);
        drive(16'hFFFD, 8'h80); expect_ev(5, 1, 0, 0, 16'h0002); tick(10);
        drive(16'hFFFF, 8'h80); expect_ev(5, 0, 0, 0, 16'h0000); tick(10);

        // Chatter every 2 cycles, then a steady press
        for (int i = 0; i < 10; i++) begin
            drive((i % 2 == 0) ? 16'hFFFD : 16'hFFFF, 8'h80);
            tick(2);
        end
        drive(16'hFFFD, 8'h80); expect_ev(5, 1, 0, 0, 16'h0002); tick(10);
        drive(16'hFFFF, 8'h80); expect_ev(5, 0, 0, 0, 16'h0000); tick(10);

        // Down-zone hysteresis: C0 enters, B0 holds, A0 exits, 90 idle
        drive(16'hFFFF, 8'hBF); tick(10);
        drive(16'hFFFF, 8'hC0); expect_ev(6, 0, 0, 1, 16'h0000); tick(10);
        drive(16'hFFFF, 8'hB0); tick(10);
        drive(16'hFFFF, 8'hA0); expect_ev(6, 0, 0, 0, 16'h0000); tick(10);
        drive(16'hFFFF, 8'h90); tick(10);

        // Up-zone: 41 ignored, 40 jumps, 50 holds, 60 exits, 40 jumps again
        drive(16'hFFFF, 8'h41); tick(10);
        drive(16'hFFFF, 8'h40); expect_ev(6, 1, 0, 0, 16'h0000); tick(10);
        drive(16'hFFFF, 8'h50); tick(10);
        drive(16'hFFFF, 8'h60); tick(10);
        drive(16'hFFFF, 8'h40); expect_ev(6, 1, 0, 0, 16'h0000); tick(10);
        drive(16'hFFFF, 8'h80); tick(10);

        // Jump priority over duck, then duck once Cross released
        drive(16'hFDFD, 8'h80); expect_ev(5, 1, 0, 0, 16'h0202); tick(10);
        drive(16'hFDFF, 8'h80); expect_ev(5, 0, 0, 1, 16'h0200); tick(10);
        drive(16'hFFFF, 8'h80); expect_ev(5, 0, 0, 0, 16'h0000); tick(10);

        // Jump and Start accepted together
        drive(16'hEFFD, 8'h80); expect_ev(5, 1, 1, 0, 16'h1002); tick(10);
        drive(16'hFFFF, 8'h80); expect_ev(5, 0, 0, 0, 16'h0000); tick(10);

        // Start with reset two cycles into the window
        drive(16'hEFFF, 8'h80); tick(2);
        rst = 1'b1; tick(2);
        rst = 1'b0; expect_ev(5, 0, 1, 0, 16'h1000); tick(10);
        drive(16'hFFFF, 8'h80); expect_ev(5, 0, 0, 0, 16'h0000); tick(20);

        check("queue_empty", exp_q.size(), 32'd0);
        check("end_duck", {31'd0, bus.duck},       32'd0);
        check("end_btn",  {16'd0, bus.btn_stable}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
